operand_fetch: RTL and testbench

- In-order issue stage between decode and execute; it is the reader of the integer register file.
- Drives both regfile read addresses, bypasses same-cycle writeback data, and tracks pending destination writes in a 32-entry scoreboard.
- Stalls on RAW/WAW hazards and registers operands into a valid/ready pipeline slot toward execute.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/operand_fetch_scoreboard.sv | 56 +++++
 rtl/operand_fetch.sv | 111 +++++++++++
 tb/tb_operand_fetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared integer-pipeline types: register index width, register count and the
// operand-fetch to execute payload.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XLEN_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN_W-1:0] rs1_val;
    logic [XLEN_W-1:0] rs2_val;
    reg_idx_t          rd;
    logic              rd_we;
  } ex_payload_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one busy bit per integer register, with lookups that
// already discount a writeback landing in the current cycle.
module operand_fetch_scoreboard
  import cpu_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     set_en_i,
  input  reg_idx_t set_idx_i,
  input  logic     clr_en_i,
  input  reg_idx_t clr_idx_i,
  input  logic     wb_valid_i,
  input  reg_idx_t wb_rd_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  input  reg_idx_t rd_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o,
  output logic     rd_busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  function automatic logic eff_busy(input logic [NUM_REGS-1:0] busy, input logic wb_v,
                                    input reg_idx_t wb_idx, input reg_idx_t idx);
    return busy[idx] && !(wb_v && (wb_idx == idx));
  endfunction

  assign rs1_busy_o = eff_busy(busy_q, wb_valid_i, wb_rd_i, rs1_i);
  assign rs2_busy_o = eff_busy(busy_q, wb_valid_i, wb_rd_i, rs2_i);
  assign rd_busy_o  = eff_busy(busy_q, wb_valid_i, wb_rd_i, rd_i);

  // Set is applied last: the issuing instruction is younger than any completing write.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i && (wb_rd_i != '0)) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    if (clr_en_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_en_i && (set_idx_i != '0)) begin
      busy_d[set_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// In-order issue stage: reads the register file, bypasses same-cycle writeback,
// stalls on RAW/WAW hazards and holds one instruction for execute.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            dec_uses_rs1,
  input  logic            dec_uses_rs2,
  input  logic [4:0]      dec_rd,
  input  logic            dec_rd_we,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we
);

  logic        ex_valid_q, ex_valid_d;
  ex_payload_t payload_q, payload_d;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        hazard, slot_free, accept, rd_we_eff, flush_clr;

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  // x0 reads as zero and is never bypassed; otherwise the writeback wins over the regfile.
  function automatic logic [XLEN-1:0] sel_operand(input reg_idx_t rs, input logic [XLEN-1:0] rf,
                                                  input logic wb_v, input reg_idx_t wb_idx,
                                                  input logic [XLEN-1:0] wb_d);
    if (rs == '0) begin
      return '0;
    end else if (wb_v && (wb_idx == rs)) begin
      return wb_d;
    end
    return rf;
  endfunction

  assign rd_we_eff = dec_rd_we && (dec_rd != '0);
  assign hazard    = (dec_uses_rs1 && rs1_busy) || (dec_uses_rs2 && rs2_busy) ||
                     (rd_we_eff && rd_busy);
  assign slot_free = !ex_valid_q || ex_ready;
  assign dec_ready = slot_free && !hazard && !flush;
  assign accept    = dec_valid && dec_ready;
  assign flush_clr = flush && ex_valid_q && payload_q.rd_we;

  operand_fetch_scoreboard u_scoreboard (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_en_i   (accept && rd_we_eff),
    .set_idx_i  (dec_rd),
    .clr_en_i   (flush_clr),
    .clr_idx_i  (payload_q.rd),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .rs1_i      (dec_rs1),
    .rs2_i      (dec_rs2),
    .rd_i       (dec_rd),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy)
  );

  always_comb begin
    ex_valid_d = ex_valid_q;
    payload_d  = payload_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d        = 1'b1;
      payload_d.rs1_val = sel_operand(dec_rs1, rf_rdata1, wb_valid, wb_rd, wb_data);
      payload_d.rs2_val = sel_operand(dec_rs2, rf_rdata2, wb_valid, wb_rd, wb_data);
      payload_d.rd      = dec_rd;
      payload_d.rd_we   = rd_we_eff;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      payload_q  <= payload_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs1_val = payload_q.rs1_val;
  assign ex_rs2_val = payload_q.rs2_val;
  assign ex_rd      = payload_q.rd;
  assign ex_rd_we   = payload_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Vector-table bench for operand_fetch with an in-order queue of expected payloads.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, rf_raddr1, rf_raddr2, wb_rd, ex_rd;
  logic        dec_uses_rs1, dec_uses_rs2, dec_rd_we, wb_valid, ex_valid, ex_ready, ex_rd_we;
  logic [31:0] rf_rdata1, rf_rdata2, wb_data, ex_rs1_val, ex_rs2_val;

  operand_fetch #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_uses_rs1 (dec_uses_rs1),
    .dec_uses_rs2 (dec_uses_rs2),
    .dec_rd       (dec_rd),
    .dec_rd_we    (dec_rd_we),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_rd        (ex_rd),
    .ex_rd_we     (ex_rd_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] rf1, rf2;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        exr, fl;
    logic        rdy, exv;
    ex_payload_t exp;
  } vec_t;

  vec_t        vecs[$];
  ex_payload_t exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic [31:0] rf1,
                     input logic [31:0] rf2, input logic wbv, input logic [4:0] wbrd,
                     input logic [31:0] wbd, input logic exr, input logic fl, input logic rdy,
                     input logic exv, input logic [31:0] e1, input logic [31:0] e2,
                     input logic [4:0] erd, input logic ewe);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.we = we;
    v.rf1 = rf1; v.rf2 = rf2; v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
    v.exr = exr; v.fl = fl; v.rdy = rdy; v.exv = exv;
    v.exp.rs1_val = e1; v.exp.rs2_val = e2; v.exp.rd = erd; v.exp.rd_we = ewe;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    dec_valid = v.dv; dec_rs1 = v.rs1; dec_uses_rs1 = v.u1; dec_rs2 = v.rs2;
    dec_uses_rs2 = v.u2; dec_rd = v.rd; dec_rd_we = v.we; rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
    wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd; ex_ready = v.exr; flush = v.fl;
  endtask

  task automatic check_slot(input string tag, input ex_payload_t e);
    check({tag, ".rs1_val"}, ex_rs1_val, e.rs1_val);
    check({tag, ".rs2_val"}, ex_rs2_val, e.rs2_val);
    check({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    check({tag, ".rd_we"}, {31'd0, ex_rd_we}, {31'd0, e.rd_we});
  endtask

  initial begin
    vec_t        idle;
    ex_payload_t zero_p;
    logic        prev_exv;

    zero_p = '0;
    idle   = '{dv: 1'b0, rs1: 5'd0, u1: 1'b0, rs2: 5'd0, u2: 1'b0, rd: 5'd0, we: 1'b0,
               rf1: 32'd0, rf2: 32'd0, wbv: 1'b0, wbrd: 5'd0, wbd: 32'd0, exr: 1'b1,
               fl: 1'b0, rdy: 1'b1, exv: 1'b0, exp: zero_p};

    //  dv rs1 u1 rs2 u2 rd we rf1 rf2 wbv wbrd wbd exr fl rdy exv | e1 e2 erd ewe
    add(1, 0, 1, 0, 0, 5, 1, 32'hDEAD, 32'hBEEF, 0, 0, 0, 1, 0, 1, 1, 0, 0, 5, 1);
    add(1, 5, 1, 0, 0, 6, 1, 32'h1111, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 1, 0, 0, 6, 1, 32'h1111, 0, 1, 5, 32'h1234, 1, 0, 1, 1, 32'h1234, 0, 6, 1);
    for (int k = 0; k < 3; k++) begin
      add(1, 5, 1, 0, 0, 7, 1, 32'h5555, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    add(1, 5, 1, 0, 0, 7, 1, 32'h5555, 0, 0, 0, 0, 1, 0, 1, 1, 32'h5555, 0, 7, 1);
    add(1, 1, 1, 2, 1, 8, 1, 32'h11, 32'h22, 0, 0, 0, 1, 0, 1, 1, 32'h11, 32'h22, 8, 1);
    add(1, 0, 1, 3, 1, 7, 1, 32'h77, 32'h33, 1, 7, 32'h7070, 1, 0, 1, 1, 0, 32'h33, 7, 1);
    add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 6, 32'h6060, 1, 0, 1, 1, 0, 0, 3, 1);
    add(1, 4, 1, 0, 0, 9, 1, 32'h44, 0, 1, 7, 32'h7777, 1, 0, 1, 1, 32'h44, 0, 9, 1);
    add(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9, 1, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 1, 0, 1, 1, 32'h99, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8, 1, 32'h1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8, 1, 32'h1, 0, 1, 8, 32'h88, 1, 0, 1, 1, 32'h1, 0, 8, 1);
    add(1, 0, 1, 0, 1, 0, 1, 32'h5, 32'h6, 1, 0, 32'hFFFF, 1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 3, 1, 3, 1, 0, 0, 32'h3, 32'h3, 1, 3, 32'h333, 1, 0, 1, 1, 32'h333, 32'h333, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 12, 1, 0, 0, 0, 0, 32'hC, 0, 1, 12, 32'hCC, 1, 0, 1, 1, 32'hCC, 0, 0, 0);

    rst = 1'b1;
    apply(idle);
    repeat (2) @(posedge clk);
    #1;
    check("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_slot("reset", zero_p);
    rst = 1'b0;
    #1;
    check("reset.idle_dec_ready", {31'd0, dec_ready}, 32'd1);

    prev_exv = 1'b0;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d.dec_ready", i), {31'd0, dec_ready}, {31'd0, vecs[i].rdy});
      check($sformatf("v%0d.raddr", i), {22'd0, rf_raddr2, rf_raddr1},
            {22'd0, vecs[i].rs2, vecs[i].rs1});
      if (prev_exv && (vecs[i].exr || vecs[i].fl) && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      if (vecs[i].dv && vecs[i].rdy) begin
        exp_q.push_back(vecs[i].exp);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d.ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exv});
      if (vecs[i].exv) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d.queue_nonempty", i), 32'd0, 32'd1);
        end else begin
          check_slot($sformatf("v%0d", i), exp_q[0]);
        end
      end
      prev_exv = vecs[i].exv;
    end

    // Reset mid-run beats flush, writeback and a same-cycle issue; busy bits clear.
    exp_q.delete();
    apply(idle);
    rst = 1'b1; flush = 1'b1; dec_valid = 1'b1; dec_rd = 5'd11; dec_rd_we = 1'b1;
    ex_ready = 1'b0; wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hABCD;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_slot("rst_mid", zero_p);
    apply(idle);
    dec_valid = 1'b1; dec_rs1 = 5'd8; dec_uses_rs1 = 1'b1; dec_rs2 = 5'd11; dec_uses_rs2 = 1'b1;
    dec_rd = 5'd11; dec_rd_we = 1'b1; rf_rdata1 = 32'hA8; rf_rdata2 = 32'hB11;
    #1;
    check("rst_mid.busy_cleared", {31'd0, dec_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_mid.issue_valid", {31'd0, ex_valid}, 32'd1);
    check_slot("rst_mid.issue", '{rs1_val: 32'hA8, rs2_val: 32'hB11, rd: 5'd11, rd_we: 1'b1});
    // The just-issued x11 writer must block a reader of x11.
    dec_rs1 = 5'd11; dec_uses_rs2 = 1'b0; dec_rd_we = 1'b0;
    #1;
    check("rst_mid.raw_x11", {31'd0, dec_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
